// File: rtl/eje6_pkg.sv
// Shared types and constants for the eje6 self-test sequencer.
package eje6_pkg;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned N_INPUTS    = 4;
  localparam int unsigned ERR_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/eje6_cmp3.sv
// Three-way equality of the canonical, SOP and POS forms of one eje6 function.
// mis is 1 when either alternate form disagrees with the canonical form.
module eje6_cmp3 (
  input  logic canon,
  input  logic sop,
  input  logic pos,
  output logic mis
);

  assign mis = (canon != sop) | (canon != pos);

endmodule

// File: rtl/eje6_secuenciador.sv
// Exhaustive self-test sequencer for the eje6 combinational block.
// Sweeps ABCD through all 16 codes, holds each for SETTLE_CYCLES cycles,
// then checks that the three forms of f, g and h agree.
// Optional macro STOP_ON_ERR_EN: end the sweep at the first mismatching code.
module eje6_secuenciador
  import eje6_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_VECTORS   = eje6_pkg::NUM_VECTORS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 A,
  output logic                 B,
  output logic                 C,
  output logic                 D,
  input  logic                 f,
  input  logic                 f_sop,
  input  logic                 f_pos,
  input  logic                 g,
  input  logic                 g_sop,
  input  logic                 g_pos,
  input  logic                 h,
  input  logic                 h_sop,
  input  logic                 h_pos,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           err_mask,
  output logic                 first_err_valid,
  output logic [N_INPUTS-1:0]  first_err_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("eje6_secuenciador: SETTLE_CYCLES must be in 1..15");
  end
  if (NUM_VECTORS != 16) begin : g_bad_nvec
    $error("eje6_secuenciador: NUM_VECTORS is fixed at 16");
  end

  localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC    = N_INPUTS'(NUM_VECTORS - 1);

  state_t                 state, state_next;
  logic [N_INPUTS-1:0]    vec, vec_next;
  logic [3:0]             cnt, cnt_next;
  logic [ERR_CNT_W-1:0]   err_count_next;
  logic [2:0]             err_mask_next;
  logic                   fev_valid_next;
  logic [N_INPUTS-1:0]    fev_next;
  logic                   pass_next;
  logic                   mis_f, mis_g, mis_h;
  logic [2:0]             mis;
  logic                   any_mis;
  logic                   sweep_end;

  eje6_cmp3 u_cmp_f (.canon(f), .sop(f_sop), .pos(f_pos), .mis(mis_f));
  eje6_cmp3 u_cmp_g (.canon(g), .sop(g_sop), .pos(g_pos), .mis(mis_g));
  eje6_cmp3 u_cmp_h (.canon(h), .sop(h_sop), .pos(h_pos), .mis(mis_h));

  assign mis     = {mis_f, mis_g, mis_h};
  assign any_mis = |mis;

  // State and datapath registers; synchronous active-low reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      vec             <= '0;
      cnt             <= '0;
      err_count       <= '0;
      err_mask        <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      pass            <= 1'b0;
    end else begin
      state           <= state_next;
      vec             <= vec_next;
      cnt             <= cnt_next;
      err_count       <= err_count_next;
      err_mask        <= err_mask_next;
      first_err_valid <= fev_valid_next;
      first_err_vec   <= fev_next;
      pass            <= pass_next;
    end
  end

  // Next-state and next-datapath logic for the sweep.
  always_comb begin
    state_next     = state;
    vec_next       = vec;
    cnt_next       = cnt;
    err_count_next = err_count;
    err_mask_next  = err_mask;
    fev_valid_next = first_err_valid;
    fev_next       = first_err_vec;
    pass_next      = pass;
    sweep_end      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next     = SETTLE;
          vec_next       = '0;
          cnt_next       = SETTLE_LOAD;
          err_count_next = '0;
          err_mask_next  = '0;
          fev_valid_next = 1'b0;
          fev_next       = '0;
          pass_next      = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_next = CHECK;
        else           cnt_next   = cnt - 4'd1;
      end
      CHECK: begin
        if (any_mis) begin
          err_count_next = err_count + ERR_CNT_W'(1);
          err_mask_next  = err_mask | mis;
          if (!first_err_valid) begin
            fev_valid_next = 1'b1;
            fev_next       = vec;
          end
        end
        sweep_end = (vec == LAST_VEC);
`ifdef STOP_ON_ERR_EN
        sweep_end = sweep_end | any_mis;
`endif
        if (sweep_end) begin
          state_next = DONE;
          pass_next  = (err_count_next == '0);
        end else begin
          state_next = SETTLE;
          vec_next   = vec + N_INPUTS'(1);
          cnt_next   = SETTLE_LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign {A, B, C, D} = vec;

endmodule
